// File: rtl/continuous_monitoring_system_pkg.sv
// Shared types and constants for the CMS trace receive path: event classes, FIFO entry layout,
// RISC-V opcode constants and the instruction classifier used by trace_pkt_decoder.
package continuous_monitoring_system_pkg;

    localparam int XLEN                     = 64;
    localparam int RISC_V_INSTRUCTION_WIDTH = 32;
    localparam int INSTR_W                  = RISC_V_INSTRUCTION_WIDTH;
    localparam int PKT_W                    = INSTR_W + XLEN;
    localparam int TRACE_DEC_FIFO_DEPTH     = 8;

    localparam logic [31:0] WFI_INSTRUCTION = 32'h1050_0073;
    localparam logic [6:0]  BRANCH_OPCODE   = 7'b110_0011;
    localparam logic [6:0]  JAL_OPCODE      = 7'b110_1111;
    localparam logic [6:0]  JALR_OPCODE     = 7'b110_0111;

    // Compressed forms are mask/match pairs on the low halfword:
    // c.beqz/c.bnez, c.jal/c.j, and c.jr/c.jalr (the latter additionally needs rs1 != 0).
    localparam logic [15:0] C_BRANCH_MASK  = 16'hC003;
    localparam logic [15:0] C_BRANCH_MATCH = 16'hC001;
    localparam logic [15:0] C_JAL_MASK     = 16'h6003;
    localparam logic [15:0] C_JAL_MATCH    = 16'h2001;
    localparam logic [15:0] C_JALR_MASK    = 16'hE07F;
    localparam logic [15:0] C_JALR_MATCH   = 16'h8002;

    typedef enum logic [2:0] {
        EVT_TIMER    = 3'd0,
        EVT_BRANCH   = 3'd1,
        EVT_JAL      = 3'd2,
        EVT_JALR     = 3'd3,
        EVT_C_BRANCH = 3'd4,
        EVT_C_JAL    = 3'd5,
        EVT_C_JALR   = 3'd6,
        EVT_WFI      = 3'd7
    } trace_evt_e;

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [XLEN-1:0]    pc;
        logic [XLEN-1:0]    delta;
        trace_evt_e         evt;
        logic               first;
        logic               gap;
    } trace_entry_t;

    function automatic trace_evt_e classify_instr(input logic [INSTR_W-1:0] instr);
        trace_evt_e evt;
        evt = EVT_TIMER;
        if (instr == WFI_INSTRUCTION) begin
            evt = EVT_WFI;
        end else if (instr[6:0] == BRANCH_OPCODE) begin
            evt = EVT_BRANCH;
        end else if (instr[6:0] == JAL_OPCODE) begin
            evt = EVT_JAL;
        end else if (instr[6:0] == JALR_OPCODE) begin
            evt = EVT_JALR;
        end else if (instr[1:0] != 2'b11) begin
            if ((instr[15:0] & C_BRANCH_MASK) == C_BRANCH_MATCH) begin
                evt = EVT_C_BRANCH;
            end else if ((instr[15:0] & C_JAL_MASK) == C_JAL_MATCH) begin
                evt = EVT_C_JAL;
            end else if (((instr[15:0] & C_JALR_MASK) == C_JALR_MATCH) && (instr[11:7] != 5'd0)) begin
                evt = EVT_C_JALR;
            end
        end
        return evt;
    endfunction

endpackage

// File: rtl/trace_pkt_decoder_if.sv
// Trace decoder bus: raw packet input from the trace port plus the valid/ready result stream.
// master = the decoder, slave = packet source and downstream consumer.
interface trace_pkt_decoder_if;
    import continuous_monitoring_system_pkg::*;

    localparam int LEVEL_W = $clog2(TRACE_DEC_FIFO_DEPTH) + 1;

    logic [PKT_W-1:0]   data_pkt;
    logic               data_pkt_valid;
    logic               out_valid;
    logic               out_ready;
    logic [INSTR_W-1:0] out_instr;
    logic [XLEN-1:0]    out_pc;
    logic [XLEN-1:0]    out_pc_delta;
    logic [2:0]         out_evt;
    logic               out_first;
    logic               out_gap;
    logic [LEVEL_W-1:0] fifo_level;

    modport master (
        input  data_pkt, data_pkt_valid, out_ready,
        output out_valid, out_instr, out_pc, out_pc_delta, out_evt, out_first, out_gap, fifo_level
    );

    modport slave (
        output data_pkt, data_pkt_valid, out_ready,
        input  out_valid, out_instr, out_pc, out_pc_delta, out_evt, out_first, out_gap, fifo_level
    );
endinterface

// File: rtl/trace_fifo.sv
// Synchronous FIFO of trace entries with a registered head output; push and pop may occur
// together, including when full (the pop frees the slot the push lands in).
module trace_fifo
    import continuous_monitoring_system_pkg::*;
#(
    parameter int DEPTH = TRACE_DEC_FIFO_DEPTH
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  trace_entry_t               wr_data,
    input  logic                       pop,
    output trace_entry_t               rd_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     level
);
    localparam int PTR_W   = $clog2(DEPTH);
    localparam int LEVEL_W = PTR_W + 1;

    trace_entry_t       mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [LEVEL_W-1:0] level_q, level_d;
    trace_entry_t       rd_data_q, rd_data_d;
    logic               pop_ok, push_ok, head_from_wr;

    assign pop_ok  = pop && (level_q != '0);
    assign push_ok = push && ((level_q != LEVEL_W'(DEPTH)) || pop_ok);
    // The incoming word becomes the head when nothing older survives this cycle's pop.
    assign head_from_wr = push_ok && (level_q == {{(LEVEL_W-1){1'b0}}, pop_ok});

    always_comb begin
        wr_ptr_d  = push_ok ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d  = pop_ok ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        level_d   = level_q + {{(LEVEL_W-1){1'b0}}, push_ok} - {{(LEVEL_W-1){1'b0}}, pop_ok};
        rd_data_d = rd_data_q;
        if ((level_d != '0) && (pop_ok || (level_q == '0))) begin
            rd_data_d = head_from_wr ? wr_data : mem[rd_ptr_d];
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_q] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            level_q   <= '0;
            rd_data_q <= '0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            level_q   <= level_d;
            rd_data_q <= rd_data_d;
        end
    end

    assign rd_data = rd_data_q;
    assign full    = (level_q == LEVEL_W'(DEPTH));
    assign empty   = (level_q == '0);
    assign level   = level_q;
endmodule

// File: rtl/trace_pkt_decoder.sv
// CMS trace port receiver: classify each {instr, pc} packet, compute PC delta and queue results.
// Define TRACE_DEC_DROP_CNT_EN to add the saturating drop_cnt output.
module trace_pkt_decoder
    import continuous_monitoring_system_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    trace_pkt_decoder_if.master bus
`ifdef TRACE_DEC_DROP_CNT_EN
    ,
    output logic [15:0]         drop_cnt
`endif
);
    localparam int DEPTH   = TRACE_DEC_FIFO_DEPTH;
    localparam int LEVEL_W = $clog2(DEPTH) + 1;

    logic               s1_valid_q, s1_valid_d;
    logic [INSTR_W-1:0] s1_instr_q, s1_instr_d;
    logic [XLEN-1:0]    s1_pc_q, s1_pc_d;
    trace_evt_e         s1_evt_q, s1_evt_d;

    logic [XLEN-1:0]    prev_pc_q, prev_pc_d;
    logic               first_pending_q, first_pending_d;
    logic               gap_pending_q, gap_pending_d;

    logic               fifo_push, fifo_pop, fifo_full, fifo_empty, drop;
    trace_entry_t       push_entry, head_entry;
    logic [LEVEL_W-1:0] fifo_level_w;

    always_comb begin
        s1_valid_d = bus.data_pkt_valid;
        s1_instr_d = s1_instr_q;
        s1_pc_d    = s1_pc_q;
        s1_evt_d   = s1_evt_q;
        if (bus.data_pkt_valid) begin
            s1_instr_d = bus.data_pkt[PKT_W-1:XLEN];
            s1_pc_d    = bus.data_pkt[XLEN-1:0];
            s1_evt_d   = classify_instr(bus.data_pkt[PKT_W-1:XLEN]);
        end
    end

    // The source cannot be stalled, so a full FIFO only accepts if its head leaves this cycle.
    assign fifo_pop  = !fifo_empty && bus.out_ready;
    assign fifo_push = s1_valid_q && (!fifo_full || fifo_pop);
    assign drop      = s1_valid_q && !fifo_push;

    always_comb begin
        push_entry.instr = s1_instr_q;
        push_entry.pc    = s1_pc_q;
        push_entry.delta = first_pending_q ? '0 : s1_pc_q - prev_pc_q;
        push_entry.evt   = s1_evt_q;
        push_entry.first = first_pending_q;
        push_entry.gap   = gap_pending_q;

        prev_pc_d       = prev_pc_q;
        first_pending_d = first_pending_q;
        gap_pending_d   = gap_pending_q;
        if (fifo_push) begin
            prev_pc_d       = s1_pc_q;
            first_pending_d = 1'b0;
            gap_pending_d   = 1'b0;
        end else if (drop) begin
            gap_pending_d   = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid_q      <= 1'b0;
            s1_instr_q      <= '0;
            s1_pc_q         <= '0;
            s1_evt_q        <= EVT_TIMER;
            prev_pc_q       <= '0;
            first_pending_q <= 1'b1;
            gap_pending_q   <= 1'b0;
        end else begin
            s1_valid_q      <= s1_valid_d;
            s1_instr_q      <= s1_instr_d;
            s1_pc_q         <= s1_pc_d;
            s1_evt_q        <= s1_evt_d;
            prev_pc_q       <= prev_pc_d;
            first_pending_q <= first_pending_d;
            gap_pending_q   <= gap_pending_d;
        end
    end

    trace_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (fifo_push),
        .wr_data (push_entry),
        .pop     (fifo_pop),
        .rd_data (head_entry),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .level   (fifo_level_w)
    );

    assign bus.out_valid    = !fifo_empty;
    assign bus.out_instr    = head_entry.instr;
    assign bus.out_pc       = head_entry.pc;
    assign bus.out_pc_delta = head_entry.delta;
    assign bus.out_evt      = head_entry.evt;
    assign bus.out_first    = head_entry.first;
    assign bus.out_gap      = head_entry.gap;
    assign bus.fifo_level   = fifo_level_w;

`ifdef TRACE_DEC_DROP_CNT_EN
    logic [15:0] drop_cnt_q, drop_cnt_d;

    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (drop && (drop_cnt_q != 16'hFFFF)) begin
            drop_cnt_d = drop_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            drop_cnt_q <= '0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign drop_cnt = drop_cnt_q;
`endif
endmodule

// File: tb/tb_trace_pkt_decoder.sv
// Self-checking bench for trace_pkt_decoder: directed scenarios then random traffic against a
// queue-based reference model. Checks drop_cnt when TRACE_DEC_DROP_CNT_EN is defined.
module tb_trace_pkt_decoder;
    import continuous_monitoring_system_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    trace_pkt_decoder_if bus ();
`ifdef TRACE_DEC_DROP_CNT_EN
    logic [15:0] drop_cnt;
`endif

    trace_pkt_decoder dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
`ifdef TRACE_DEC_DROP_CNT_EN
        ,
        .drop_cnt (drop_cnt)
`endif
    );

    typedef struct {
        logic [31:0] instr;
        logic [63:0] pc;
        logic [63:0] delta;
        logic [2:0]  evt;
        logic        first;
        logic        gap;
    } exp_t;

    exp_t        q[$];
    exp_t        last_out;
    logic        pipe_v;
    logic [31:0] pipe_instr;
    logic [63:0] pipe_pc;
    logic [63:0] m_prev;
    logic        m_first, m_gap;
    int          m_drops;
    int          n_total = 0, n_pass = 0, n_fail = 0;

    // Event class straight from the RISC-V encoding rules, by field.
    function automatic logic [2:0] ref_evt(input logic [31:0] i);
        logic [15:0] c;
        c = i[15:0];
        if (i == 32'h1050_0073) return 3'd7;
        if (i[6:0] == 7'h63) return 3'd1;
        if (i[6:0] == 7'h6F) return 3'd2;
        if (i[6:0] == 7'h67) return 3'd3;
        if (i[1:0] != 2'b11) begin
            if (c[1:0] == 2'b01 && c[15:14] == 2'b11) return 3'd4;
            if (c[1:0] == 2'b01 && (c[15:13] == 3'b001 || c[15:13] == 3'b101)) return 3'd5;
            if (c[1:0] == 2'b10 && c[15:13] == 3'b100 && c[11:7] != 5'd0 && c[6:2] == 5'd0) return 3'd6;
        end
        return 3'd0;
    endfunction

    task automatic model_reset();
        q.delete();
        last_out = '{default: 0};
        pipe_v   = 1'b0;
        m_prev   = '0;
        m_first  = 1'b1;
        m_gap    = 1'b0;
        m_drops  = 0;
    endtask

    task automatic model_edge(input logic v, input logic [31:0] instr, input logic [63:0] pc, input logic rdy);
        exp_t e;
        if (q.size() > 0 && rdy) begin
            last_out = q.pop_front();
            $display("txn pc=%h instr=%h evt=%0d delta=%h first=%0d gap=%0d",
                     last_out.pc, last_out.instr, last_out.evt, last_out.delta, last_out.first, last_out.gap);
        end
        if (pipe_v) begin
            if (q.size() < TRACE_DEC_FIFO_DEPTH) begin
                e.instr = pipe_instr;
                e.pc    = pipe_pc;
                e.delta = m_first ? 64'd0 : pipe_pc - m_prev;
                e.evt   = ref_evt(pipe_instr);
                e.first = m_first;
                e.gap   = m_gap;
                q.push_back(e);
                m_prev  = pipe_pc;
                m_first = 1'b0;
                m_gap   = 1'b0;
            end else begin
                m_gap = 1'b1;
                if (m_drops < 65535) m_drops++;
            end
        end
        pipe_v     = v;
        pipe_instr = instr;
        pipe_pc    = pc;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_total++;
        assert (obs === expv) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic check_outputs(input string ctx);
        exp_t h;
        if (q.size() > 0) h = q[0];
        else h = last_out;
        chk({ctx, ".out_valid"}, 64'(bus.out_valid), 64'(q.size() > 0));
        chk({ctx, ".fifo_level"}, 64'(bus.fifo_level), 64'(q.size()));
        chk({ctx, ".out_instr"}, 64'(bus.out_instr), 64'(h.instr));
        chk({ctx, ".out_pc"}, bus.out_pc, h.pc);
        chk({ctx, ".out_pc_delta"}, bus.out_pc_delta, h.delta);
        chk({ctx, ".out_evt"}, 64'(bus.out_evt), 64'(h.evt));
        chk({ctx, ".out_first"}, 64'(bus.out_first), 64'(h.first));
        chk({ctx, ".out_gap"}, 64'(bus.out_gap), 64'(h.gap));
`ifdef TRACE_DEC_DROP_CNT_EN
        chk({ctx, ".drop_cnt"}, 64'(drop_cnt), 64'(m_drops));
`endif
    endtask

    task automatic cycle(input logic v, input logic [31:0] instr, input logic [63:0] pc, input logic rdy,
                         input string ctx);
        bus.data_pkt_valid = v;
        bus.data_pkt       = {instr, pc};
        bus.out_ready      = rdy;
        check_outputs(ctx);
        @(posedge clk);
        model_edge(v, instr, pc, rdy);
        #1;
    endtask

    task automatic idle(input int n, input logic rdy, input string ctx);
        for (int k = 0; k < n; k++) cycle(1'b0, 32'h0, 64'h0, rdy, ctx);
    endtask

    task automatic do_reset(input logic v, input logic [31:0] instr, input logic [63:0] pc);
        rst_n              = 1'b0;
        bus.data_pkt_valid = v;
        bus.data_pkt       = {instr, pc};
        bus.out_ready      = 1'b0;
        @(posedge clk);
        model_reset();
        #1;
        rst_n              = 1'b1;
        bus.data_pkt_valid = 1'b0;
    endtask

    logic [31:0] pool [8];
    logic [31:0] ri;
    logic [63:0] rpc;

    initial begin
        pool[0] = 32'h0000_006F; pool[1] = 32'h0000_0063; pool[2] = 32'h0000_8067; pool[3] = 32'h1050_0073;
        pool[4] = 32'h0000_C001; pool[5] = 32'h0000_A001; pool[6] = 32'h0000_9082; pool[7] = 32'h0000_0013;
        rst_n = 1'b0;
        bus.data_pkt_valid = 1'b0;
        bus.data_pkt = '0;
        bus.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        do_reset(1'b0, 32'h0, 64'h0);
        idle(1, 1'b0, "reset");

        // First packet after reset
        cycle(1'b1, 32'h0000_006F, 64'h1000, 1'b0, "jal");
        idle(1, 1'b0, "jal");
        chk("jal.valid_2cyc", 64'(bus.out_valid), 64'd1);
        chk("jal.evt", 64'(bus.out_evt), 64'd2);
        chk("jal.first", 64'(bus.out_first), 64'd1);
        chk("jal.delta", bus.out_pc_delta, 64'd0);
        idle(1, 1'b1, "jal");

        // Delta between consecutive deliveries, including wrap
        cycle(1'b1, 32'h0000_0063, 64'h1000, 1'b0, "br");
        cycle(1'b1, 32'h0000_0063, 64'h1010, 1'b0, "br");
        idle(1, 1'b0, "br");
        idle(1, 1'b1, "br");
        chk("br.evt", 64'(bus.out_evt), 64'd1);
        chk("br.delta", bus.out_pc_delta, 64'h10);
        idle(1, 1'b1, "br");
        cycle(1'b1, 32'h0000_0013, 64'hFFFF_FFFF_FFFF_FFF0, 1'b0, "wrap");
        cycle(1'b1, 32'h0000_0013, 64'h0, 1'b0, "wrap");
        idle(1, 1'b0, "wrap");
        idle(1, 1'b1, "wrap");
        chk("wrap.delta", bus.out_pc_delta, 64'h10);
        idle(1, 1'b1, "wrap");

        // Event classes
        cycle(1'b1, 32'h1050_0073, 64'h2000, 1'b0, "evt");
        cycle(1'b1, 32'h0000_8082, 64'h2004, 1'b0, "evt");
        cycle(1'b1, 32'h0000_0013, 64'h2006, 1'b0, "evt");
        idle(1, 1'b0, "evt");
        chk("evt.wfi", 64'(bus.out_evt), 64'd7);
        idle(1, 1'b1, "evt");
        chk("evt.c_jr", 64'(bus.out_evt), 64'd6);
        idle(1, 1'b1, "evt");
        chk("evt.nop", 64'(bus.out_evt), 64'd0);
        idle(1, 1'b1, "evt");

        // Overflow: 10 packets into a stalled consumer
        for (int i = 0; i < 10; i++) cycle(1'b1, 32'h0000_0013, 64'h2000 + 64'(i * 4), 1'b0, "ovf");
        idle(2, 1'b0, "ovf");
        chk("ovf.level", 64'(bus.fifo_level), 64'd8);
`ifdef TRACE_DEC_DROP_CNT_EN
        chk("ovf.drop_cnt", 64'(drop_cnt), 64'd2);
`endif
        idle(8, 1'b1, "drain");
        cycle(1'b1, 32'h0000_0063, 64'h3000, 1'b0, "gap");
        idle(2, 1'b0, "gap");
        chk("gap.out_gap", 64'(bus.out_gap), 64'd1);
        chk("gap.delta", bus.out_pc_delta, 64'hFE4);
        idle(1, 1'b1, "gap");

        // Full FIFO: arrival coinciding with a pop is accepted
        for (int i = 0; i < 8; i++) cycle(1'b1, 32'h0000_006F, 64'h4000 + 64'(i * 8), 1'b0, "full");
        idle(1, 1'b0, "full");
        cycle(1'b1, 32'h0000_0067, 64'h5000, 1'b0, "full");
        idle(1, 1'b1, "full");
        idle(1, 1'b0, "full");
        chk("full.level", 64'(bus.fifo_level), 64'd8);
`ifdef TRACE_DEC_DROP_CNT_EN
        chk("full.drop_cnt", 64'(drop_cnt), 64'd2);
`endif
        idle(9, 1'b1, "drain");

        // Reset with entries queued and packets in flight
        for (int i = 0; i < 4; i++) cycle(1'b1, 32'h0000_0063, 64'h6000 + 64'(i * 4), 1'b0, "rst");
        do_reset(1'b1, 32'h0000_0063, 64'h6010);
        chk("rst.out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst.level", 64'(bus.fifo_level), 64'd0);
        cycle(1'b1, 32'h0000_0063, 64'h7000, 1'b0, "rst");
        idle(1, 1'b0, "rst");
        chk("rst.first", 64'(bus.out_first), 64'd1);
        idle(1, 1'b1, "rst");

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            ri  = ($urandom_range(0, 3) == 0) ? $urandom : pool[$urandom_range(0, 7)];
            rpc = ($urandom_range(0, 1) == 0) ? {$urandom, $urandom} : pipe_pc + 64'($urandom_range(0, 64));
            cycle($urandom_range(0, 99) < 70, ri, rpc,
                  (i % 100 < 30) ? ($urandom_range(0, 9) == 0) : ($urandom_range(0, 99) < 60), "rand");
        end
        idle(12, 1'b1, "final");
        check_outputs("final");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
